// File: rtl/transaction_ctrl.sv
// transaction_ctrl: main sequencer for the transaction-layer datapath.
// It moves the layer through RESET, INIT, IDLE, ACTIVE and a sticky ERROR state.
//
// Ports:
//   clk, reset_L (sync, active-low)
//   init            request to enter or stay in configuration
//   umbral_A*_in    requested almost-full / almost-empty thresholds
//   empty_fifos     empty flags [3:0] input FIFOs, [7:4] output FIFOs
//   error_fifos     overflow/underflow flags, same bit order
//   umbral_A*_out   active thresholds broadcast to all eight FIFOs
//   state           one-hot {ERROR, ACTIVE, IDLE, INIT, RESET}
//   idle_out, active_out, error_out, arb_enable: status decoded from state
//   error_id        lowest-numbered failing FIFO at entry to ERROR
module transaction_ctrl #(
    parameter int PTR_W      = 3,
    parameter int AF_DEFAULT = 6,
    parameter int AE_DEFAULT = 1
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             init,
    input  logic [PTR_W-1:0] umbral_AF_in,
    input  logic [PTR_W-1:0] umbral_AE_in,
    input  logic [7:0]       empty_fifos,
    input  logic [7:0]       error_fifos,
    output logic [PTR_W-1:0] umbral_AF_out,
    output logic [PTR_W-1:0] umbral_AE_out,
    output logic [4:0]       state,
    output logic             idle_out,
    output logic             active_out,
    output logic             error_out,
    output logic             arb_enable,
    output logic [2:0]       error_id
);

    localparam logic [4:0] S_RESET  = 5'b00001;
    localparam logic [4:0] S_INIT   = 5'b00010;
    localparam logic [4:0] S_IDLE   = 5'b00100;
    localparam logic [4:0] S_ACTIVE = 5'b01000;
    localparam logic [4:0] S_ERROR  = 5'b10000;

    logic [4:0] next_state;
    logic [2:0] err_idx;
    logic       any_err;
    logic       all_empty;
    logic       cfg_ok;

    assign any_err   = |error_fifos;
    assign all_empty = &empty_fifos;
    assign cfg_ok    = umbral_AE_in < umbral_AF_in;

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        err_idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (error_fifos[i]) err_idx = 3'(i);
        end
    end

    always_comb begin
        next_state = state;
        unique case (1'b1)
            state[0]: next_state = S_INIT;
            state[1]: begin
                if (any_err)    next_state = S_ERROR;
                else if (!init) next_state = S_IDLE;
            end
            state[2]: begin
                if (any_err)         next_state = S_ERROR;
                else if (init)       next_state = S_INIT;
                else if (!all_empty) next_state = S_ACTIVE;
            end
            state[3]: begin
                if (any_err)        next_state = S_ERROR;
                else if (init)      next_state = S_INIT;
                else if (all_empty) next_state = S_IDLE;
            end
            state[4]: next_state = S_ERROR;
            default:  next_state = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state         <= S_RESET;
            umbral_AF_out <= PTR_W'(AF_DEFAULT);
            umbral_AE_out <= PTR_W'(AE_DEFAULT);
            error_id      <= '0;
        end else begin
            state <= next_state;
            // Invalid pairs (AE >= AF) are dropped; old values hold.
            if (state[1] && cfg_ok) begin
                umbral_AF_out <= umbral_AF_in;
                umbral_AE_out <= umbral_AE_in;
            end
            if (!state[4] && next_state[4]) error_id <= err_idx;
        end
    end

    assign idle_out   = state[2];
    assign active_out = state[3];
    assign error_out  = state[4];
    assign arb_enable = state[3];

endmodule

// File: tb/tb_transaction_ctrl.sv
// tb_transaction_ctrl: directed plus randomized checks of transaction_ctrl
// against a mode-number reference model.
module tb_transaction_ctrl;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       init;
    logic [2:0] af_in;
    logic [2:0] ae_in;
    logic [7:0] empty_fifos;
    logic [7:0] error_fifos;
    logic [2:0] af_out;
    logic [2:0] ae_out;
    logic [4:0] state;
    logic       idle_out;
    logic       active_out;
    logic       error_out;
    logic       arb_enable;
    logic [2:0] error_id;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: mode 0=RESET 1=INIT 2=IDLE 3=ACTIVE 4=ERROR
    int m_mode = 0;
    int m_af   = 6;
    int m_ae   = 1;
    int m_eid  = 0;

    always #5 clk = ~clk;

    transaction_ctrl dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .init         (init),
        .umbral_AF_in (af_in),
        .umbral_AE_in (ae_in),
        .empty_fifos  (empty_fifos),
        .error_fifos  (error_fifos),
        .umbral_AF_out(af_out),
        .umbral_AE_out(ae_out),
        .state        (state),
        .idle_out     (idle_out),
        .active_out   (active_out),
        .error_out    (error_out),
        .arb_enable   (arb_enable),
        .error_id     (error_id)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_edge();
        if (!reset_L) begin
            m_mode = 0;
            m_af   = 6;
            m_ae   = 1;
            m_eid  = 0;
        end else begin
            if (m_mode == 1 && int'(ae_in) < int'(af_in)) begin
                m_af = int'(af_in);
                m_ae = int'(ae_in);
            end
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode != 4 && error_fifos != 0) begin
                m_mode = 4;
                for (int b = 0; b < 8; b++) begin
                    if (error_fifos[b]) begin
                        m_eid = b;
                        break;
                    end
                end
            end else if (m_mode == 1) begin
                if (!init) m_mode = 2;
            end else if (m_mode == 2 || m_mode == 3) begin
                if (init) m_mode = 1;
                else if (empty_fifos == 8'hFF) m_mode = 2;
                else m_mode = 3;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("state", 32'(state), 32'(1 << m_mode));
        check("idle", 32'(idle_out), 32'(m_mode == 2));
        check("active", 32'(active_out), 32'(m_mode == 3));
        check("error", 32'(error_out), 32'(m_mode == 4));
        check("arb_en", 32'(arb_enable), 32'(m_mode == 3));
        check("af", 32'(af_out), 32'(m_af));
        check("ae", 32'(ae_out), 32'(m_ae));
        check("err_id", 32'(error_id), 32'(m_eid));
    endtask

    initial begin
        reset_L     = 1'b0;
        init        = 1'b0;
        af_in       = 3'd0;
        ae_in       = 3'd0;
        empty_fifos = 8'hFF;
        error_fifos = 8'h00;
        #2;
        step();
        step();
        check("rst_state", 32'(state), 32'h01);

        reset_L = 1'b1;
        step();
        check("init_after_rst", 32'(state), 32'h02);
        step();
        check("idle_after_init", 32'(state), 32'h04);
        check("dflt_af", 32'(af_out), 32'd6);
        check("dflt_ae", 32'(ae_out), 32'd1);

        init  = 1'b1;
        af_in = 3'd5;
        ae_in = 3'd2;
        repeat (3) step();
        init = 1'b0;
        step();
        check("cfg_af", 32'(af_out), 32'd5);
        check("cfg_ae", 32'(ae_out), 32'd2);
        check("cfg_idle", 32'(state), 32'h04);

        init  = 1'b1;
        af_in = 3'd2;
        ae_in = 3'd4;
        repeat (3) step();
        init = 1'b0;
        step();
        check("bad_cfg_af", 32'(af_out), 32'd5);
        check("bad_cfg_ae", 32'(ae_out), 32'd2);

        empty_fifos = 8'hFB;
        step();
        check("go_active", 32'(state), 32'h08);
        check("arb_on", 32'(arb_enable), 32'd1);
        empty_fifos = 8'hFF;
        step();
        check("back_idle", 32'(state), 32'h04);
        check("arb_off", 32'(arb_enable), 32'd0);

        empty_fifos = 8'hFB;
        step();
        error_fifos = 8'b0101_0000;
        init        = 1'b1;
        step();
        check("err_state", 32'(state), 32'h10);
        check("err_id4", 32'(error_id), 32'd4);
        error_fifos = 8'h01;
        init        = 1'b0;
        for (int k = 0; k < 4; k++) begin
            empty_fifos = 8'($urandom);
            init        = 1'($urandom);
            step();
        end
        check("err_sticky", 32'(state), 32'h10);
        check("err_id_hold", 32'(error_id), 32'd4);

        reset_L = 1'b0;
        step();
        check("rst_from_err", 32'(state), 32'h01);
        check("rst_err_id", 32'(error_id), 32'd0);
        check("rst_af", 32'(af_out), 32'd6);
        reset_L     = 1'b1;
        error_fifos = 8'h00;
        init        = 1'b1;
        af_in       = 3'd7;
        ae_in       = 3'd3;
        step();
        check("init_after_err", 32'(state), 32'h02);
        step();
        check("load_af7", 32'(af_out), 32'd7);
        reset_L = 1'b0;
        step();
        check("midinit_af", 32'(af_out), 32'd6);
        check("midinit_ae", 32'(ae_out), 32'd1);
        reset_L = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            reset_L = ($urandom_range(0, 39) != 0);
            init    = ($urandom_range(0, 5) == 0);
            af_in   = 3'($urandom);
            ae_in   = 3'($urandom);
            if ($urandom_range(0, 1) == 0) empty_fifos = 8'hFF;
            else empty_fifos = ~(8'd1 << $urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) error_fifos = 8'($urandom);
            else error_fifos = 8'h00;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
